// File: rtl/mips_mem_responder_pkg.sv
// Shared memory-map constants and state/region types for the MIPS memory responder.
package mips_mem_responder_pkg;

  localparam logic [31:0] I_START_ADDRESS = 32'h0000_0000;
  localparam logic [31:0] D_START_ADDRESS = 32'h0000_2000;
  localparam logic [31:0] IO_BASE_ADDRESS = 32'h0000_8000;

  // Byte offsets inside the 4-word MMIO window.
  localparam logic [3:0] IO_LED_OFF  = 4'h0;
  localparam logic [3:0] IO_CNT_OFF  = 4'h4;
  localparam logic [3:0] IO_STAT_OFF = 4'h8;

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

  typedef enum logic [1:0] {RegNone, RegInstr, RegData, RegIo} region_e;

endpackage

// File: rtl/mips_mem_responder_if.sv
// Core-to-memory request/ready bus.
interface mips_mem_responder_if #(
  parameter int unsigned N = 32
);
  logic         req;
  logic         MemWrite;
  logic [N-1:0] addr;
  logic [N-1:0] write_data;
  logic [N-1:0] read_data;
  logic         ready;

  modport master (
    output req, MemWrite, addr, write_data,
    input  read_data, ready
  );

  modport slave (
    input  req, MemWrite, addr, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/mips_sync_ram.sv
// Single-port RAM with one-cycle synchronous read (read-before-write on the same edge).
module mips_sync_ram #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [N-1:0]  wdata,
  output logic [N-1:0]  rdata
);
  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder: instruction RAM, data RAM and MMIO behind a req/ready
// handshake with programmable wait states.
module mips_mem_responder
  import mips_mem_responder_pkg::*;
#(
  parameter int unsigned  N           = 32,
  parameter int unsigned  DEPTH       = 1024,
  parameter int unsigned  WAIT_STATES = 1,
  parameter logic [N-1:0] I_BASE      = N'(I_START_ADDRESS),
  parameter logic [N-1:0] D_BASE      = N'(D_START_ADDRESS),
  parameter logic [N-1:0] IO_BASE     = N'(IO_BASE_ADDRESS)
) (
  input  logic                      clk,
  input  logic                      rst,
  mips_mem_responder_if.slave       bus,
  output logic                      bus_err,
  output logic [7:0]                leds
);
  localparam int unsigned  AW        = $clog2(DEPTH);
  localparam logic [N-1:0] SPAN      = N'(4 * DEPTH);
  localparam logic [N-1:0] IO_SPAN   = N'(16);
  localparam logic [3:0]   WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e       state_q, state_d;
  logic [3:0]   wcnt_q, wcnt_d;
  logic [N-1:0] addr_q, wdata_q;
  logic         we_q;
  logic         ready_q;
  logic [N-1:0] read_data_q;
  logic         err_q, err_d;
  logic [7:0]   led_q, led_d;
  logic [N-1:0] cnt_q;

  logic [N-1:0] i_off, d_off, io_off;
  region_e      region;
  logic         misaligned, access_err, io_wr, dram_we;
  logic [N-1:0] iram_rdata, dram_rdata, resp_data;

  // Decode always runs on the latched address so mid-transaction bus changes are harmless.
  always_comb begin
    i_off      = addr_q - I_BASE;
    d_off      = addr_q - D_BASE;
    io_off     = addr_q - IO_BASE;
    misaligned = (addr_q[1:0] != 2'b00);
    if (i_off < SPAN)        region = RegInstr;
    else if (d_off < SPAN)   region = RegData;
    else if (io_off < IO_SPAN) region = RegIo;
    else                     region = RegNone;
    access_err = misaligned || (region == RegNone) || ((region == RegInstr) && we_q);
    io_wr      = we_q && (region == RegIo) && !misaligned;
    dram_we    = (state_q == StAccess) && we_q && (region == RegData) && !misaligned && rst;
  end

  mips_sync_ram #(.N(N), .DEPTH(DEPTH)) u_iram (
    .clk   (clk),
    .we    (1'b0),
    .addr  (i_off[AW+1:2]),
    .wdata (wdata_q),
    .rdata (iram_rdata)
  );

  mips_sync_ram #(.N(N), .DEPTH(DEPTH)) u_dram (
    .clk   (clk),
    .we    (dram_we),
    .addr  (d_off[AW+1:2]),
    .wdata (wdata_q),
    .rdata (dram_rdata)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    led_d   = led_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          state_d = (WAIT_STATES > 0) ? StWait : StAccess;
          wcnt_d  = WAIT_LOAD;
        end
      end
      StWait: begin
        if (wcnt_q == 4'd0) state_d = StAccess;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      StAccess: begin
        state_d = StResp;
        if (io_wr && (io_off[3:0] == IO_LED_OFF)) led_d = wdata_q[7:0];
        if (io_wr && (io_off[3:0] == IO_STAT_OFF) && wdata_q[0]) err_d = 1'b0;
        // A fresh error overrides a same-cycle clear.
        if (access_err) err_d = 1'b1;
      end
      StResp: state_d = StIdle;
    endcase
  end

  always_comb begin
    resp_data = '0;
    if (!we_q && !access_err) begin
      case (region)
        RegInstr: resp_data = iram_rdata;
        RegData:  resp_data = dram_rdata;
        RegIo: begin
          case (io_off[3:0])
            IO_LED_OFF:  resp_data = N'(led_q);
            IO_CNT_OFF:  resp_data = cnt_q;
            IO_STAT_OFF: resp_data = N'(err_q);
            default:     resp_data = '0;
          endcase
        end
        default:  resp_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      wcnt_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      ready_q     <= 1'b0;
      read_data_q <= '0;
      err_q       <= 1'b0;
      led_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      led_q   <= led_d;
      cnt_q   <= cnt_q + N'(1);
      ready_q <= (state_q == StResp);
      if (state_q == StResp) read_data_q <= resp_data;
      if ((state_q == StIdle) && bus.req) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.write_data;
        we_q    <= bus.MemWrite;
      end
    end
  end

  assign bus.ready     = ready_q;
  assign bus.read_data = read_data_q;
  assign bus_err       = err_q;
  assign leds          = led_q;
endmodule
